button_reset_conditioner: RTL and testbench

- Conditions the raw board reset push-button into a clean, debounced, active-low reset request.
- Its `_o_rst` output drives the `_rst` input of the downstream reset-sequencing stage.
- Synchronises the asynchronous button, rejects bounce/glitches and enforces a minimum assertion width.
- Flags a long press for the capture logic (e.g. full trigger-config clear).

---
 rtl/button_reset_conditioner_pkg.sv | 27 ++
 rtl/button_reset_conditioner_bit_synchronizer.sv | 25 ++
 rtl/button_reset_conditioner.sv | 206 ++++++++++++++++++++
 tb/tb_button_reset_conditioner.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_reset_conditioner_pkg.sv
// Shared definitions for the push-button reset conditioner: FSM state
// encoding and the helpers used to size its saturating counters.
package button_reset_conditioner_pkg;

    // FSM state encoding, 3 bits wide.
    localparam logic [2:0] ST_INIT        = 3'd0;
    localparam logic [2:0] ST_IDLE        = 3'd1;
    localparam logic [2:0] ST_DEB_PRESS   = 3'd2;
    localparam logic [2:0] ST_ASSERT      = 3'd3;
    localparam logic [2:0] ST_HOLD        = 3'd4;
    localparam logic [2:0] ST_DEB_RELEASE = 3'd5;

    // Bits needed to hold every value from 0 up to max_count inclusive.
    function automatic int count_width(input int max_count);
        if (max_count < 1) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

    // Larger of two integers; the shared counter must cover both the
    // debounce length and the minimum assertion window.
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_reset_conditioner_bit_synchronizer.sv
// Two-flop synchroniser for a single asynchronous bit. The reset value is
// a parameter so the flops can clear to the input's idle level.
module bit_synchronizer #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input, cleared to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_reset_conditioner.sv
// Push-button reset conditioner. Synchronises the raw button, debounces
// press and release, holds the reset request low for a minimum width and
// pulses o_long_press once when the button has been held long enough.
// Every output is a flop; the only asynchronous path is the reset clear.
module button_reset_conditioner
    import button_reset_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CLOCKS   = 1000,
    parameter int MIN_ASSERT_CLOCKS = 16,
    parameter int LONG_PRESS_CLOCKS = 50000000,
    parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic i_clk,
    input  logic _rst,
    input  logic i_btn,
    output logic _o_rst,
    output logic o_btn_level,
    output logic o_long_press,
    output logic o_busy
);

    // One counter serves INIT, both debounce states and the ASSERT window,
    // so it is sized for the larger of the two lengths.
    localparam int CNT_W  = count_width(max_of(DEBOUNCE_CLOCKS, MIN_ASSERT_CLOCKS));
    localparam int LONG_W = count_width(LONG_PRESS_CLOCKS);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CLOCKS);
    localparam logic [CNT_W-1:0]  MIN_LAST  = CNT_W'(MIN_ASSERT_CLOCKS - 1);
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_PRESS_CLOCKS);
    localparam logic [LONG_W-1:0] LONG_FIRE = LONG_W'(LONG_PRESS_CLOCKS - 1);

`ifndef SYNTHESIS
    // Elaboration-time sanity check of the parameter set.
    initial begin
        if (DEBOUNCE_CLOCKS < 1) begin
            $error("button_reset_conditioner: DEBOUNCE_CLOCKS must be >= 1");
        end
        if (MIN_ASSERT_CLOCKS < 1) begin
            $error("button_reset_conditioner: MIN_ASSERT_CLOCKS must be >= 1");
        end
        if (LONG_PRESS_CLOCKS <= MIN_ASSERT_CLOCKS) begin
            $error("button_reset_conditioner: LONG_PRESS_CLOCKS must exceed MIN_ASSERT_CLOCKS");
        end
    end
`endif

    logic              btn_sync;
    logic              pressed;
    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              level_next;
    logic [LONG_W-1:0] long_cnt;
    logic [LONG_W-1:0] long_cnt_next;
    logic              long_active;
    logic              long_fire;

    // The synchroniser clears to the raw not-pressed level so that a reset
    // never produces a phantom press.
    bit_synchronizer #(
        .RESET_VALUE (BTN_ACTIVE_LOW)
    ) u_btn_sync (
        .clk   (i_clk),
        .rst_n (_rst),
        .d     (i_btn),
        .q     (btn_sync)
    );

    // Normalise polarity: pressed is 1 while the button is held.
    assign pressed = btn_sync ^ BTN_ACTIVE_LOW;

    // Next-state, shared counter and debounced-level decisions.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = o_btn_level;
        case (state)
            ST_INIT: begin
                // Hold the reset request for the minimum width after
                // power-up; a button already held goes straight to HOLD.
                if (cnt == MIN_LAST) begin
                    cnt_next = '0;
                    if (pressed) begin
                        state_next = ST_HOLD;
                        level_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (pressed) begin
                    state_next = ST_DEB_PRESS;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            ST_DEB_PRESS: begin
                // The counter holds the number of pressed samples already
                // seen; once it has reached the target the press is accepted.
                if (cnt >= DEB_LAST) begin
                    state_next = ST_ASSERT;
                    cnt_next   = '0;
                    level_next = 1'b1;
                end else if (!pressed) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_ASSERT: begin
                // The button is ignored until the minimum window has elapsed.
                if (cnt == MIN_LAST) begin
                    if (pressed) begin
                        state_next = ST_HOLD;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_DEB_RELEASE;
                        cnt_next   = CNT_ONE;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!pressed) begin
                    state_next = ST_DEB_RELEASE;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            ST_DEB_RELEASE: begin
                if (cnt >= DEB_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    level_next = 1'b0;
                end else if (pressed) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

    // Long-press counter: runs while the reset request is held for a press,
    // saturates at the threshold and is cleared everywhere else. Because it
    // only returns to zero outside the pressed states, it fires once per press.
    always_comb begin
        long_active = (state == ST_ASSERT) || (state == ST_HOLD) ||
                      (state == ST_DEB_RELEASE);
        long_fire   = long_active && (long_cnt == LONG_FIRE);
        long_cnt_next = '0;
        if (long_active) begin
            if (long_cnt == LONG_MAX) begin
                long_cnt_next = LONG_MAX;
            end else begin
                long_cnt_next = long_cnt + LONG_ONE;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
            state    <= ST_INIT;
            cnt      <= '0;
            long_cnt <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            long_cnt <= long_cnt_next;
        end
    end

    // Registered outputs, decoded from the next state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
            _o_rst       <= 1'b0;
            o_btn_level  <= 1'b0;
            o_long_press <= 1'b0;
            o_busy       <= 1'b1;
        end else begin
            _o_rst       <= (state_next == ST_IDLE) || (state_next == ST_DEB_PRESS);
            o_btn_level  <= level_next;
            o_long_press <= long_fire;
            o_busy       <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_button_reset_conditioner.sv
// Testbench for button_reset_conditioner: table-driven directed sequences,
// hand-written reset corner cases and a randomised run checked against a
// run-length reference model of the button conditioner.
module tb_button_reset_conditioner;

    localparam int D    = 8;
    localparam int MIN  = 4;
    localparam int LONG = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_in;
    logic btn;
    logic dut_rst;
    logic level;
    logic long_press;
    logic busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    button_reset_conditioner #(
        .DEBOUNCE_CLOCKS   (D),
        .MIN_ASSERT_CLOCKS (MIN),
        .LONG_PRESS_CLOCKS (LONG),
        .BTN_ACTIVE_LOW    (1'b1)
    ) dut (
        .i_clk        (clk),
        ._rst         (rst_in),
        .i_btn        (btn),
        ._o_rst       (dut_rst),
        .o_btn_level  (level),
        .o_long_press (long_press),
        .o_busy       (busy)
    );

    // ---------------- scoreboard ----------------
    int tests;
    int fails;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Run-length view: count consecutive samples opposing the current
    // debounced level, accept after D of them, ignore the button for the
    // first MIN-1 edges after an accepted press, pulse when the press has
    // lasted LONG edges.
    int   m_init_left;
    int   m_run;
    int   m_ignore;
    int   m_since;
    bit   m_low;
    bit   m_level;
    bit   m_pulse;
    logic hist[$];

    function automatic logic [3:0] model_out();
        logic r;
        logic b;
        r = (m_init_left == 0) && !m_low;
        b = (m_init_left > 0) || m_low || (m_run > 0);
        return {r, m_level, m_pulse, b};
    endfunction

    task automatic model_reset();
        m_init_left = MIN;
        m_run       = 0;
        m_ignore    = 0;
        m_since     = 0;
        m_low       = 1'b0;
        m_level     = 1'b0;
        m_pulse     = 1'b0;
        hist.delete();
        hist.push_back(1'b1);
        hist.push_back(1'b1);
    endtask

    task automatic model_step(input logic b);
        logic raw;
        bit   p;
        raw = hist.pop_front();
        hist.push_back(b);
        p = (raw == 1'b0);
        m_pulse = 1'b0;
        if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0 && p) begin
                m_low = 1'b1; m_level = 1'b1; m_since = 0; m_ignore = 0; m_run = 0;
            end
        end else if (m_low) begin
            m_since++;
            if (m_since == LONG) m_pulse = 1'b1;
            if (m_ignore > 0) begin
                m_ignore--;
            end else if (m_run == D) begin
                m_low = 1'b0; m_level = 1'b0; m_run = 0;
            end else begin
                m_run = p ? 0 : m_run + 1;
            end
        end else begin
            if (m_run == D) begin
                m_low = 1'b1; m_level = 1'b1; m_since = 0; m_ignore = MIN - 1; m_run = 0;
            end else begin
                m_run = p ? m_run + 1 : 0;
            end
        end
        exp_q.push_back(model_out());
    endtask

    task automatic check_scoreboard();
        logic [3:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : model_out();
        check("model {rst,level,long,busy}", {28'd0, dut_rst, level, long_press, busy}, {28'd0, exp});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic b;
        b = btn;
        @(posedge clk);
        if (rst_in) model_step(b);
        #1;
        check_scoreboard();
    endtask

    // Called #1 after a rising edge, so reset changes land mid-cycle.
    task automatic assert_reset();
        rst_in = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        check_scoreboard();
    endtask

    task automatic release_reset();
        rst_in = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string name;
        logic  btn;
        int    ticks;
        logic  rst;
        logic  level;
        logic  busy;
        logic  long_last;
        int    pulses;
        bit    steady;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic b, input int ticks, input logic r,
                       input logic l, input logic bz, input logic lp, input int pulses,
                       input bit steady);
        vec_t v;
        v.name = name; v.btn = b; v.ticks = ticks; v.rst = r; v.level = l; v.busy = bz;
        v.long_last = lp; v.pulses = pulses; v.steady = steady;
        vecs.push_back(v);
    endtask

    task automatic apply_vec(input vec_t v);
        int pulses;
        int bad;
        pulses = 0;
        bad = 0;
        btn = v.btn;
        for (int i = 0; i < v.ticks; i++) begin
            tick();
            if (long_press === 1'b1) pulses++;
            if ({dut_rst, level} !== {v.rst, v.level}) bad++;
        end
        check({v.name, " _o_rst"}, dut_rst, v.rst);
        check({v.name, " o_btn_level"}, level, v.level);
        check({v.name, " o_busy"}, busy, v.busy);
        check({v.name, " o_long_press"}, long_press, v.long_last);
        check({v.name, " pulse count"}, pulses, v.pulses);
        if (v.steady) check({v.name, " steady ticks off"}, bad, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        tests = 0;
        fails = 0;
        rst_in = 1'b1;
        btn = 1'b1;
        model_reset();
        #2;
        assert_reset();
        check("reset _o_rst", dut_rst, 1'b0);
        check("reset o_btn_level", level, 1'b0);
        check("reset o_long_press", long_press, 1'b0);
        check("reset o_busy", busy, 1'b1);
        repeat (3) tick();
        release_reset();

        // name, btn, ticks, rst, level, busy, long_last, pulses, steady
        add("powerup low",      1'b1, 3,  1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        add("powerup release",  1'b1, 1,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        add("idle settle",      1'b1, 5,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        add("glitch low",       1'b0, 7,  1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        add("glitch tail",      1'b1, 2,  1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        add("glitch idle",      1'b1, 1,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        add("gap1",             1'b1, 5,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        add("press debounce",   1'b0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        add("press assert",     1'b0, 1,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        add("press hold",       1'b0, 9,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("release debounce", 1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("release idle",     1'b1, 1,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        add("gap2",             1'b1, 5,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        add("long debounce",    1'b0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        add("long assert",      1'b0, 1,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        add("long wait",        1'b0, 31, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("long pulse",       1'b0, 1,  1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        add("long after",       1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("long release",     1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("long idle",        1'b1, 1,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        add("gap3",             1'b1, 5,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        add("bounce press",     1'b0, 11, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        add("bounce press end", 1'b0, 3,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("bounce 1",         1'b1, 3,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("bounce 2",         1'b0, 3,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("bounce 3",         1'b1, 3,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("bounce 4",         1'b0, 3,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("bounce 5",         1'b1, 3,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("bounce settle",    1'b1, 7,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add("bounce idle",      1'b1, 1,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        add("gap4",             1'b1, 5,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i]);
        end

        // Reset two cycles into ASSERT: outputs clear at once, then the
        // minimum width runs again from reset release.
        btn = 1'b0;
        repeat (11) tick();
        check("midassert entered _o_rst", dut_rst, 1'b0);
        repeat (2) tick();
        assert_reset();
        check("midassert reset _o_rst", dut_rst, 1'b0);
        check("midassert reset o_btn_level", level, 1'b0);
        check("midassert reset o_busy", busy, 1'b1);
        btn = 1'b1;
        repeat (2) tick();
        release_reset();
        repeat (3) tick();
        check("midassert init _o_rst", dut_rst, 1'b0);
        tick();
        check("midassert release _o_rst", dut_rst, 1'b1);
        check("midassert release o_busy", busy, 1'b0);

        // Button held across reset release: INIT goes to HOLD and the
        // request stays low until a debounced release.
        repeat (3) tick();
        btn = 1'b0;
        assert_reset();
        repeat (2) tick();
        release_reset();
        repeat (4) tick();
        check("held init _o_rst", dut_rst, 1'b0);
        check("held init o_btn_level", level, 1'b1);
        repeat (10) tick();
        check("held hold _o_rst", dut_rst, 1'b0);
        btn = 1'b1;
        repeat (10) tick();
        check("held release pending _o_rst", dut_rst, 1'b0);
        tick();
        check("held release _o_rst", dut_rst, 1'b1);
        check("held release o_btn_level", level, 1'b0);

        // Randomised runs of bounce, glitches, clean and long presses, with
        // occasional mid-operation resets, checked against the model.
        for (int s = 0; s < 150; s++) begin
            int len;
            if ($urandom_range(0, 39) == 0) begin
                assert_reset();
                repeat ($urandom_range(1, 3)) tick();
                release_reset();
            end
            btn = ~btn;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 12);
            repeat (len) tick();
        end
        btn = 1'b1;
        repeat (60) tick();
        check("final idle _o_rst", dut_rst, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
